data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the multicycle core's data/instruction port. Accepts one request at a
//  time from the controller's mem_en/mem_read/mem_write strobes and services it against an internal
//  word array with programmable wait states. Byte, half and word lanes come from mem_data_length.
//  Returns right-justified, zero-extended read data with a one-cycle mem_ready pulse; the core's
//  load unit performs sign extension.
// PARAMETERS
//  ADDR_W       32    byte-address width
//  DEPTH_WORDS  1024  storage depth in 32-bit words (power of 2)
//  WAIT_STATES  2     extra cycles between acceptance and response (0..15)
// PORTS
//  clk              in   1       single clock, all logic on rising edge
//  rst              in   1       synchronous, active-high reset
//  mem_en           in   1       request qualifier
//  mem_read         in   1       read request
//  mem_write        in   1       write request
//  mem_addr         in   ADDR_W  byte address
//  mem_wdata        in   32      write data, right-justified
//  mem_data_length  in   2       2'b00 word, 2'b01 half, 2'b10 byte, 2'b11 reserved
//  mem_rdata        out  32      read data, right-justified, zero-extended
//  mem_ready        out  1       one-cycle completion pulse
//  mem_err          out  1       valid with mem_ready; request faulted
//  busy             out  1       high from acceptance until the cycle after mem_ready
// BEHAVIOUR
//  - Reset: state=IDLE, mem_rdata=0, mem_ready=0, mem_err=0, busy=0, wait counter=0.
//    The storage array is not cleared.
//  - Reset mid-operation: an in-flight write not yet committed is dropped; no mem_ready is issued.
//  - FSM states IDLE, WAIT, RESP:
//    IDLE -> WAIT when mem_en && (mem_read|mem_write) and WAIT_STATES>0.
//    IDLE -> RESP when the same request is seen and WAIT_STATES==0.
//    WAIT counts WAIT_STATES cycles, then goes to RESP.
//    RESP lasts exactly 1 cycle (mem_ready=1), then returns to IDLE.
//  - Acceptance latches addr, wdata, length and rd/wr. Inputs are ignored while busy.
//  - Latency: mem_ready asserts WAIT_STATES+1 cycles after the acceptance edge.
//    Back-to-back requests are accepted no earlier than the cycle after RESP.
//  - Writes commit on the RESP edge, using byte enables only:
//    word 4'b1111; half 4'b0011<<addr[1]*2; byte 4'b0001<<addr[1:0].
//  - Reads: mem_rdata = (word >> 8*addr[1:0]) masked to 8/16/32 bits.
//    mem_rdata is updated at RESP and held until the next RESP.
//  - Error (mem_err=1 with mem_ready, no array write, mem_rdata=0) when any of:
//    mem_read && mem_write together; length 2'b11; half with addr[0]=1; word with addr[1:0]!=0;
//    word index >= DEPTH_WORDS.
//  - mem_en=0 with rd/wr asserted is ignored; mem_en=1 alone is ignored.
//  - Wait counter is $clog2(16) bits and reloads at every acceptance; no wrap is possible.
// STRUCTURE
//  - mem_pkg: constants LEN_WORD/LEN_HALF/LEN_BYTE (2'b00/2'b01/2'b10), FSM state encodings
//    S_IDLE/S_WAIT/S_RESP. Controller mux constants are to be moved here too.
//  - Sub-module mem_lane_align (combinational): length, addr[1:0] -> byte enables, write-data
//    replication, read extract and misalignment flag.
//  - Top holds the FSM, request latches, wait counter and the storage array.
// TESTING
//  1 Word write/read: write 0xDEADBEEF to 0x10, then read 0x10, WAIT_STATES=2
//    -> mem_ready 3 cycles after each acceptance; rdata=0xDEADBEEF, err=0.
//  2 Byte lanes: write byte 0xAA to 0x13, then read word 0x10 -> 0xAAADBEEF; read byte 0x13 -> 0x000000AA.
//  3 Misaligned: read half at 0x11 and read word at 0x12 -> mem_ready with err=1, rdata=0.
//    A write-half to 0x11 leaves memory unchanged.
//  4 Rd+wr conflict and out-of-range: read&write together -> err=1; addr=4*DEPTH_WORDS -> err=1;
//    array unchanged in both cases.
//  5 Reset mid-WAIT: write 0x12345678 to 0x20, assert rst in WAIT -> no mem_ready;
//    a later read of 0x20 returns the prior value.
//  6 WAIT_STATES=0 build: requests every other cycle -> each mem_ready one cycle after acceptance;
//    requests asserted while busy are not accepted.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared constants and FSM encoding for the data memory responder
package data_mem_responder_pkg;

   localparam logic [1:0] LEN_WORD = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_BYTE = 2'b10;

   localparam int WAIT_W = $clog2(16);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between the core controller and the responder
interface data_mem_responder_if #(
   parameter int ADDR_W = 32
);
   logic              mem_en;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [1:0]        mem_data_length;
   logic [31:0]       mem_rdata;
   logic              mem_ready;
   logic              mem_err;
   logic              busy;

   modport master (
      output mem_en, mem_read, mem_write, mem_addr, mem_wdata, mem_data_length,
      input  mem_rdata, mem_ready, mem_err, busy
   );

   modport slave (
      input  mem_en, mem_read, mem_write, mem_addr, mem_wdata, mem_data_length,
      output mem_rdata, mem_ready, mem_err, busy
   );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// rtl/data_mem_responder_lane_align.sv - byte-lane enables, write replication and read extraction
module data_mem_responder_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic [1:0]  len,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata,
   output logic        misaligned
);

   logic [31:0] shifted;

   // The reserved length is reported as misaligned so the top has one fault source per lane check.
   always_comb begin
      shifted    = rword >> {addr_lo, 3'b000};
      byte_en    = 4'b0000;
      wdata_rep  = wdata;
      rdata      = 32'h0;
      misaligned = 1'b0;
      case (len)
         LEN_WORD: begin
            byte_en    = 4'b1111;
            rdata      = shifted;
            misaligned = (addr_lo != 2'b00);
         end
         LEN_HALF: begin
            byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_rep  = {2{wdata[15:0]}};
            rdata      = {16'h0, shifted[15:0]};
            misaligned = addr_lo[0];
         end
         LEN_BYTE: begin
            byte_en    = 4'b0001 << addr_lo;
            wdata_rep  = {4{wdata[7:0]}};
            rdata      = {24'h0, shifted[7:0]};
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding memory responder with programmable wait states
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
)(
   input logic                 clk,
   input logic                 rst,
   data_mem_responder_if.slave bus
);

   localparam int                IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

   state_t              state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [ADDR_W-1:0]   req_addr;
   logic [31:0]         req_wdata;
   logic [1:0]          req_len;
   logic                req_rd;
   logic                req_wr;
   logic [31:0]         rdata_q;
   logic                ready_q;
   logic                err_q;
   logic                busy_q;

   logic [31:0]         mem [DEPTH_WORDS];

   logic [IDX_W-1:0]    word_idx;
   logic [31:0]         rword;
   logic [31:0]         wdata_rep;
   logic [31:0]         rdata_al;
   logic [3:0]          byte_en;
   logic                misaligned;
   logic                out_of_range;
   logic                fault;
   logic                accept;

   assign word_idx     = req_addr[IDX_W+1:2];
   assign out_of_range = (req_addr >> (IDX_W + 2)) != '0;
   assign fault        = (req_rd && req_wr) || misaligned || out_of_range;
   assign rword        = mem[word_idx];
   assign accept       = bus.mem_en && (bus.mem_read || bus.mem_write)
                         && !busy_q && (state == S_IDLE);

   data_mem_responder_lane_align u_lane (
      .len        (req_len),
      .addr_lo    (req_addr[1:0]),
      .wdata      (req_wdata),
      .rword      (rword),
      .byte_en    (byte_en),
      .wdata_rep  (wdata_rep),
      .rdata      (rdata_al),
      .misaligned (misaligned)
   );

   // busy stays up through the mem_ready cycle, so the earliest re-acceptance is the edge after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_len   <= LEN_WORD;
         req_rd    <= 1'b0;
         req_wr    <= 1'b0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (ready_q) begin
            busy_q <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  req_addr  <= bus.mem_addr;
                  req_wdata <= bus.mem_wdata;
                  req_len   <= bus.mem_data_length;
                  req_rd    <= bus.mem_read;
                  req_wr    <= bus.mem_write;
                  busy_q    <= 1'b1;
                  wait_cnt  <= WAIT_LOAD;
                  state     <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - WAIT_W'(1);
               if (wait_cnt <= WAIT_W'(1)) begin
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               ready_q  <= 1'b1;
               err_q    <= fault;
               rdata_q  <= (fault || req_wr) ? 32'h0 : rdata_al;
               wait_cnt <= '0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Storage is deliberately left out of reset; a reset landing on the RESP edge drops the write.
   always_ff @(posedge clk) begin
      if (!rst && state == S_RESP && req_wr && !fault) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
         end
      end
   end

   assign bus.mem_rdata = rdata_q;
   assign bus.mem_ready = ready_q;
   assign bus.mem_err   = err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   localparam int DEPTH_A = 1024;
   localparam int DEPTH_B = 64;

   logic clk;
   logic rst;

   data_mem_responder_if #(.ADDR_W(32)) bus_a ();
   data_mem_responder_if #(.ADDR_W(32)) bus_b ();

   data_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH_A), .WAIT_STATES(2)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   data_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH_B), .WAIT_STATES(0)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [1:0]  len;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t        tbl[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [7:0]  mb [4*DEPTH_A];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int which, input bit en, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] len);
      if (which == 0) begin
         bus_a.mem_en = en; bus_a.mem_read = rd; bus_a.mem_write = wr;
         bus_a.mem_addr = addr; bus_a.mem_wdata = wd; bus_a.mem_data_length = len;
      end else begin
         bus_b.mem_en = en; bus_b.mem_read = rd; bus_b.mem_write = wr;
         bus_b.mem_addr = addr; bus_b.mem_wdata = wd; bus_b.mem_data_length = len;
      end
   endtask

   function automatic logic get_ready(input int which);
      return (which == 0) ? bus_a.mem_ready : bus_b.mem_ready;
   endfunction
   function automatic logic get_busy(input int which);
      return (which == 0) ? bus_a.busy : bus_b.busy;
   endfunction
   function automatic logic get_err(input int which);
      return (which == 0) ? bus_a.mem_err : bus_b.mem_err;
   endfunction
   function automatic logic [31:0] get_rdata(input int which);
      return (which == 0) ? bus_a.mem_rdata : bus_b.mem_rdata;
   endfunction

   // Called #1 after a rising edge with the DUT idle; lat = edges from acceptance to mem_ready, -1 on timeout.
   task automatic req(input int which, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [1:0] len,
                      output logic [31:0] rdata, output logic err, output int lat);
      bit seen;
      drive(which, 1'b1, rd, wr, addr, wd, len);
      @(posedge clk); #1;
      drive(which, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      seen = 1'b0;
      lat  = -1;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(posedge clk); #1;
         if (get_ready(which)) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      rdata = get_rdata(which);
      err   = get_err(which);
      @(posedge clk); #1;
   endtask

   // Byte-addressed little-endian reference for the WAIT_STATES=2 instance.
   function automatic void model(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [1:0] len,
                                 output logic [31:0] er, output logic ee);
      int n;
      case (len)
         2'd0:    n = 4;
         2'd1:    n = 2;
         2'd2:    n = 1;
         default: n = 0;
      endcase
      ee = (rd && wr) || (n == 0) || (addr >= 32'(4 * DEPTH_A));
      if (n != 0 && (addr % n) != 0) ee = 1'b1;
      er = 32'h0;
      if (!ee) begin
         for (int i = 0; i < n; i++) begin
            if (wr) mb[addr + i] = wd[8*i +: 8];
            else    er[8*i +: 8] = mb[addr + i];
         end
      end
   endfunction

   function automatic void add(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [1:0] len,
                               input logic [31:0] exp_rdata, input bit exp_err);
      tbl.push_back('{rd: rd, wr: wr, addr: addr, wd: wd, len: len,
                      exp_rdata: exp_rdata, exp_err: exp_err});
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd_v;
      logic        er_v;
      int          lat;
      logic [31:0] exp_rd;
      logic        exp_er;
      bit          seen;
      int          free_at;
      bit          exp_rdy [0:20];
      bit          exp_bsy [0:20];
      bit          acc     [0:20];

      add(0, 1, 32'h00, 32'h0BADF00D, LEN_WORD, 32'h0,        0);
      add(0, 1, 32'h10, 32'hDEADBEEF, LEN_WORD, 32'h0,        0);
      add(1, 0, 32'h10, 32'h0,        LEN_WORD, 32'hDEADBEEF, 0);
      add(0, 1, 32'h13, 32'h000000AA, LEN_BYTE, 32'h0,        0);
      add(1, 0, 32'h10, 32'h0,        LEN_WORD, 32'hAAADBEEF, 0);
      add(1, 0, 32'h13, 32'h0,        LEN_BYTE, 32'h000000AA, 0);
      add(1, 0, 32'h11, 32'h0,        LEN_HALF, 32'h0,        1);
      add(1, 0, 32'h12, 32'h0,        LEN_WORD, 32'h0,        1);
      add(0, 1, 32'h11, 32'h00005555, LEN_HALF, 32'h0,        1);
      add(1, 0, 32'h10, 32'h0,        LEN_WORD, 32'hAAADBEEF, 0);
      add(1, 1, 32'h10, 32'h11111111, LEN_WORD, 32'h0,        1);
      add(1, 0, 32'h10, 32'h0,        LEN_WORD, 32'hAAADBEEF, 0);
      add(0, 1, 32'h1000, 32'h22222222, LEN_WORD, 32'h0,      1);
      add(1, 0, 32'h1000, 32'h0,      LEN_WORD, 32'h0,        1);
      add(1, 0, 32'h00, 32'h0,        LEN_WORD, 32'h0BADF00D, 0);
      add(1, 0, 32'h10, 32'h0,        2'b11,    32'h0,        1);
      add(1, 0, 32'h12, 32'h0,        LEN_HALF, 32'h0000AAAD, 0);
      add(1, 0, 32'h11, 32'h0,        LEN_BYTE, 32'h000000BE, 0);
      add(0, 1, 32'h12, 32'h98761234, LEN_HALF, 32'h0,        0);
      add(1, 0, 32'h10, 32'h0,        LEN_WORD, 32'h1234BEEF, 0);
      add(0, 1, 32'h10, 32'h00000077, LEN_BYTE, 32'h0,        0);
      add(1, 0, 32'h10, 32'h0,        LEN_WORD, 32'h1234BE77, 0);

      rst = 1'b1;
      drive(0, 0, 0, 0, 32'h0, 32'h0, 2'b00);
      drive(1, 0, 0, 0, 32'h0, 32'h0, 2'b00);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int w = 0; w < 2; w++) begin
         check($sformatf("reset_ready_%0d", w), 32'(get_ready(w)), 32'h0);
         check($sformatf("reset_err_%0d", w),   32'(get_err(w)),   32'h0);
         check($sformatf("reset_busy_%0d", w),  32'(get_busy(w)),  32'h0);
         check($sformatf("reset_rdata_%0d", w), get_rdata(w),      32'h0);
      end

      foreach (tbl[i]) begin
         req(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].len, rd_v, er_v, lat);
         check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd3);
         check($sformatf("tbl%0d_err", i), 32'(er_v), 32'(tbl[i].exp_err));
         if (tbl[i].rd || tbl[i].exp_err)
            check($sformatf("tbl%0d_rdata", i), rd_v, tbl[i].exp_rdata);
      end

      // Requests without a full qualifier must never start a transaction.
      for (int m = 0; m < 2; m++) begin
         if (m == 0) drive(0, 0, 1, 0, 32'h10, 32'h0, LEN_WORD);
         else        drive(0, 1, 0, 0, 32'h10, 32'h0, LEN_WORD);
         seen = 1'b0;
         repeat (5) begin
            @(posedge clk); #1;
            if (get_busy(0) || get_ready(0)) seen = 1'b1;
         end
         check($sformatf("ignored_req_%0d", m), 32'(seen), 32'h0);
      end
      drive(0, 0, 0, 0, 32'h0, 32'h0, 2'b00);

      req(0, 0, 1, 32'h20, 32'hCAFEF00D, LEN_WORD, rd_v, er_v, lat);
      drive(0, 1, 0, 1, 32'h20, 32'h12345678, LEN_WORD);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 32'h0, 32'h0, 2'b00);
      check("rst_mid_busy_before", 32'(get_busy(0)), 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (get_ready(0)) seen = 1'b1;
      end
      check("rst_mid_no_ready", 32'(seen), 32'h0);
      check("rst_mid_busy_after", 32'(get_busy(0)), 32'h0);
      req(0, 1, 0, 32'h20, 32'h0, LEN_WORD, rd_v, er_v, lat);
      check("rst_mid_readback", rd_v, 32'hCAFEF00D);
      check("rst_mid_readback_err", 32'(er_v), 32'h0);

      // Randomised traffic over a 32-word window, preloaded so the reference knows every byte.
      for (int i = 0; i < 32; i++) begin
         model(0, 1, 32'(4 * i), 32'h0, LEN_WORD, exp_rd, exp_er);
         req(0, 0, 1, 32'(4 * i), 32'h0, LEN_WORD, rd_v, er_v, lat);
      end
      for (int n = 0; n < 150; n++) begin
         bit          r_rd, r_wr;
         logic [31:0] r_addr, r_wd;
         logic [1:0]  r_len;
         int          op;
         op = $urandom_range(0, 9);
         r_rd = (op == 0) || (op >= 5);
         r_wr = (op <= 4);
         r_len  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         r_addr = 32'($urandom_range(0, 127));
         if ($urandom_range(0, 15) == 0) r_addr = 32'h1000 + 32'($urandom_range(0, 255));
         r_wd = $urandom;
         model(r_rd, r_wr, r_addr, r_wd, r_len, exp_rd, exp_er);
         req(0, r_rd, r_wr, r_addr, r_wd, r_len, rd_v, er_v, lat);
         check($sformatf("rnd%0d_latency", n), 32'(lat), 32'd3);
         check($sformatf("rnd%0d_err", n), 32'(er_v), 32'(exp_er));
         if (r_rd || exp_er)
            check($sformatf("rnd%0d_rdata a=%h len=%0d", n, r_addr, r_len), rd_v, exp_rd);
      end

      // Zero-wait instance: requests offered every other cycle, accepted only once busy has dropped.
      for (int c = 0; c < 16; c += 2) begin
         req(1, 0, 1, 32'(4 * c), 32'h0, LEN_WORD, rd_v, er_v, lat);
         check($sformatf("b_pre%0d_latency", c), 32'(lat), 32'd1);
      end
      for (int c = 0; c <= 20; c++) begin
         exp_rdy[c] = 1'b0;
         exp_bsy[c] = 1'b0;
         acc[c]     = 1'b0;
      end
      free_at = 0;
      for (int c = 0; c < 20; c++) begin
         if (c < 16 && c % 2 == 0) drive(1, 1, 0, 1, 32'(4 * c), 32'hB0000000 + 32'(c), LEN_WORD);
         else                      drive(1, 0, 0, 0, 32'h0, 32'h0, 2'b00);
         @(posedge clk); #1;
         if (c < 16 && c % 2 == 0 && c >= free_at) begin
            acc[c]       = 1'b1;
            exp_bsy[c]   = 1'b1;
            exp_bsy[c+1] = 1'b1;
            exp_rdy[c+1] = 1'b1;
            free_at      = c + 3;
         end
         check($sformatf("b_ready_c%0d", c), 32'(get_ready(1)), 32'(exp_rdy[c]));
         check($sformatf("b_busy_c%0d", c),  32'(get_busy(1)),  32'(exp_bsy[c]));
      end
      drive(1, 0, 0, 0, 32'h0, 32'h0, 2'b00);
      for (int c = 0; c < 16; c += 2) begin
         req(1, 1, 0, 32'(4 * c), 32'h0, LEN_WORD, rd_v, er_v, lat);
         check($sformatf("b_read%0d_latency", c), 32'(lat), 32'd1);
         check($sformatf("b_read%0d_rdata", c), rd_v, acc[c] ? 32'hB0000000 + 32'(c) : 32'h0);
      end
      req(1, 1, 0, 32'(4 * DEPTH_B), 32'h0, LEN_WORD, rd_v, er_v, lat);
      check("b_oor_err", 32'(er_v), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
